// File: rtl/slowclk_edge_monitor.sv
// slowclk_edge_monitor: synchronizes an asynchronous slow clock into clk_in,
// emits registered rise/fall strobes, measures the slow-clock period,
// declares frequency lock and flags loss of clock.
// Optional duty-cycle checking is built when SLOWCLK_DUTY_CHECK_EN is defined.
module slowclk_edge_monitor #(
  parameter int NOM_PERIOD = 125,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 9
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_err,
  output logic             locked,
  output logic             lost
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, LOST} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              s1_d, s2_d, s3_d;
  logic              rise_stb_q, rise_stb_d;
  logic              fall_stb_q, fall_stb_d;
  logic              period_vld_q, period_vld_d;
  logic              locked_q, locked_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [GC_W-1:0]   good_cnt_q, good_cnt_d;

  logic rise_det, fall_det, active, meas, good_meas, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // |p - NOM_PERIOD| <= TOL using a one-bit-wider signed difference
  function automatic logic in_tol(input logic [CNT_W-1:0] p);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, p}) - $signed((CNT_W+1)'(NOM_PERIOD));
    if (diff[CNT_W]) diff = -diff;
    return (diff <= $signed((CNT_W+1)'(TOL)));
  endfunction

`ifdef SLOWCLK_DUTY_CHECK_EN
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             duty_err_q, duty_err_d;
  logic             duty_good;

  // |2*ht - p| <= 2*TOL+1, two extra bits cover the doubling and the sign
  function automatic logic duty_ok(input logic [CNT_W-1:0] ht,
                                   input logic [CNT_W-1:0] p);
    logic signed [CNT_W+1:0] diff;
    diff = $signed({1'b0, ht, 1'b0}) - $signed({2'b00, p});
    if (diff[CNT_W+1]) diff = -diff;
    return (diff <= $signed((CNT_W+2)'(2 * TOL + 1)));
  endfunction

  assign duty_good = duty_ok(high_time_q, per_cnt_q);
`else
  logic duty_good;
  assign duty_good = 1'b1;
`endif

  assign rise_det  = s2_q & ~s3_q;
  assign fall_det  = ~s2_q & s3_q;
  assign active    = (state_q == ACQ) || (state_q == LOCK);
  assign meas      = rise_det && active;
  assign good_meas = meas && in_tol(per_cnt_q) && duty_good;
  assign timeout   = active && !rise_det && (per_cnt_q == CNT_W'(TIMEOUT));

  // Synchronizer, strobes, period counter, lock accounting and FSM next state
  always_comb begin
    s1_d         = slow_clk;
    s2_d         = s1_q;
    s3_d         = s2_q;
    rise_stb_d   = rise_det;
    fall_stb_d   = fall_det;
    period_vld_d = meas;
    period_d     = period_q;
    good_cnt_d   = good_cnt_q;
    state_d      = state_q;
    per_cnt_d    = rise_det ? CNT_W'(1) : sat_inc(per_cnt_q);

    if (meas) period_d = per_cnt_q;

    if (meas) begin
      if (!good_meas)                            good_cnt_d = '0;
      else if (good_cnt_q != GC_W'(LOCK_COUNT))  good_cnt_d = good_cnt_q + GC_W'(1);
    end
    if (timeout) good_cnt_d = '0;

    case (state_q)
      IDLE: if (rise_det) state_d = ACQ;
      ACQ: begin
        if (timeout) state_d = LOST;
        else if (good_meas && good_cnt_d == GC_W'(LOCK_COUNT)) state_d = LOCK;
      end
      LOCK: begin
        if (timeout) state_d = LOST;
        else if (meas && !good_meas) state_d = ACQ;
      end
      LOST: if (rise_det) state_d = ACQ;
      default: state_d = IDLE;
    endcase

    // locked trails the state by a cycle, but loss drops it immediately
    locked_d = (state_q == LOCK) && (state_d != LOST);
    lost_d   = (state_d == LOST);
  end

  // Control and measurement registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      rise_stb_q   <= 1'b0;
      fall_stb_q   <= 1'b0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
      per_cnt_q    <= '0;
      period_q     <= '0;
      good_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      rise_stb_q   <= rise_stb_d;
      fall_stb_q   <= fall_stb_d;
      period_vld_q <= period_vld_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
      per_cnt_q    <= per_cnt_d;
      period_q     <= period_d;
      good_cnt_q   <= good_cnt_d;
    end
  end

`ifdef SLOWCLK_DUTY_CHECK_EN
  // High-phase counter and duty error pulse
  always_comb begin
    hi_cnt_d    = hi_cnt_q;
    high_time_d = high_time_q;
    duty_err_d  = meas && !duty_good;
    if (rise_det)  hi_cnt_d = CNT_W'(1);
    else if (s2_q) hi_cnt_d = sat_inc(hi_cnt_q);
    if (fall_det)  high_time_d = hi_cnt_q;
  end

  // Duty-check registers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      hi_cnt_q    <= '0;
      high_time_q <= '0;
      duty_err_q  <= 1'b0;
    end else begin
      hi_cnt_q    <= hi_cnt_d;
      high_time_q <= high_time_d;
      duty_err_q  <= duty_err_d;
    end
  end

  assign high_time = high_time_q;
  assign duty_err  = duty_err_q;
`else
  assign high_time = '0;
  assign duty_err  = 1'b0;
`endif

  assign rise_stb   = rise_stb_q;
  assign fall_stb   = fall_stb_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_slowclk_edge_monitor.sv
// Directed bench for slowclk_edge_monitor. Expectations for the optional
// duty check follow SLOWCLK_DUTY_CHECK_EN when it is defined for the build.
module tb_slowclk_edge_monitor;

  localparam int CNT_W = 9;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             slow_clk = 1'b0;
  logic             rise_stb, fall_stb, period_vld, duty_err, locked, lost;
  logic [CNT_W-1:0] period, high_time;

  slowclk_edge_monitor #(
    .NOM_PERIOD(125), .TOL(2), .LOCK_COUNT(4), .TIMEOUT(256), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk),
    .rise_stb(rise_stb), .fall_stb(fall_stb),
    .period(period), .period_vld(period_vld),
    .high_time(high_time), .duty_err(duty_err),
    .locked(locked), .lost(lost)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_rise, n_fall, n_vld, n_derr, n_lockup, n_both;
  int rise_cyc, fall_cyc, vld_cyc, last_per, min_per, max_per;
  int lock_gap, lock_vld_n, unlock_gap, lock_dn_cyc, lost_up_cyc, lost_dn_cyc;
  int rise_set, fall_set;
  logic locked_prev = 1'b0;
  logic lost_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_rise = 0; n_fall = 0; n_vld = 0; n_derr = 0; n_lockup = 0; n_both = 0;
    rise_cyc = -1; fall_cyc = -1; vld_cyc = -1; last_per = -1;
    min_per = 1 << 30; max_per = -1;
    lock_gap = -1; lock_vld_n = -1; unlock_gap = -1;
    lock_dn_cyc = -1; lost_up_cyc = -1; lost_dn_cyc = -1;
  endtask

  // Advance one clk_in cycle and record what the outputs did after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (rise_stb) begin n_rise++; rise_cyc = cyc; end
    if (fall_stb) begin n_fall++; fall_cyc = cyc; end
    if (period_vld) begin
      n_vld++; vld_cyc = cyc; last_per = int'(period);
      if (int'(period) < min_per) min_per = int'(period);
      if (int'(period) > max_per) max_per = int'(period);
    end
    if (duty_err) n_derr++;
    if (locked && !locked_prev) begin
      n_lockup++; lock_gap = cyc - vld_cyc; lock_vld_n = n_vld;
    end
    if (!locked && locked_prev) begin
      unlock_gap = cyc - vld_cyc; lock_dn_cyc = cyc;
    end
    if (lost && !lost_prev) lost_up_cyc = cyc;
    if (!lost && lost_prev) lost_dn_cyc = cyc;
    if (locked && lost) n_both++;
    locked_prev = locked;
    lost_prev = lost;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic periods(input int n, input int hi, input int lo);
    repeat (n) begin
      slow_clk = 1'b1; rise_set = cyc + 1;
      ticks(hi);
      slow_clk = 1'b0;
      ticks(lo);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {8'd0, rise_stb, fall_stb, period_vld, duty_err, locked, lost,
              period, high_time}, 32'd0);
  endtask

  initial begin
    clear_stats();
    rst_n = 1'b0; slow_clk = 1'b0;
    ticks(2);
    chk_reset_outs("reset_outputs");
    rst_n = 1'b1;

    // Isolated edges: strobe on the cycle after edge k+2, one cycle wide
    ticks(3);
    slow_clk = 1'b1; rise_set = cyc + 1;
    ticks(6);
    chk("iso_rise_time", rise_cyc, rise_set + 2);
    chk("iso_rise_width", n_rise, 1);
    chk("iso_first_rise_no_vld", n_vld, 0);
    slow_clk = 1'b0; fall_set = cyc + 1;
    ticks(6);
    chk("iso_fall_time", fall_cyc, fall_set + 2);
    chk("iso_fall_width", n_fall, 1);

    // Nominal 63/62 clock from reset: lock after the 5th rise
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    clear_stats();
    periods(5, 63, 62);
    chk("nom_rises", n_rise, 5);
    chk("nom_vlds", n_vld, 4);
    chk("nom_period_min", min_per, 125);
    chk("nom_period_max", max_per, 125);
    chk("nom_vld_with_rise", vld_cyc, rise_cyc);
    chk("nom_locked", locked, 1);
    chk("nom_lock_after_vld", lock_gap, 1);
    chk("nom_lock_at_vld_n", lock_vld_n, 4);
    chk("nom_duty_err", n_derr, 0);
`ifdef SLOWCLK_DUTY_CHECK_EN
    chk("nom_high_time", high_time, 63);
`else
    chk("nom_high_time", high_time, 0);
`endif

    // One late edge: 130-cycle period drops lock, four good periods restore it
    clear_stats();
    periods(1, 63, 67);
    periods(1, 63, 62);
    chk("late_period", last_per, 130);
    chk("late_unlock_gap", unlock_gap, 1);
    chk("late_locked", locked, 0);
    clear_stats();
    periods(4, 63, 62);
    chk("relock_vlds", n_vld, 4);
    chk("relock_period", max_per, 125);
    chk("relock_locked", locked, 1);
    chk("relock_gap", lock_gap, 1);
    chk("relock_at_vld_n", lock_vld_n, 4);

    // Clock stops: loss one cycle after per_cnt reaches 256
    clear_stats();
    periods(1, 63, 62);
    ticks(200);
    chk("loss_lost", lost, 1);
    chk("loss_locked", locked, 0);
    chk("loss_time", lost_up_cyc, rise_set + 258);
    chk("loss_unlock_time", lock_dn_cyc, rise_set + 258);
    chk("loss_never_both", n_both, 0);
    clear_stats();
    periods(1, 63, 62);
    chk("resume_no_vld", n_vld, 0);
    chk("resume_lost_clear", lost, 0);
    chk("resume_lost_clear_time", lost_dn_cyc, rise_set + 2);
    clear_stats();
    periods(4, 63, 62);
    chk("resume_locked", locked, 1);
    chk("resume_lock_at_vld_n", lock_vld_n, 4);
    chk("resume_never_both", n_both, 0);

    // Reset mid-period while locked
    slow_clk = 1'b1; ticks(63);
    slow_clk = 1'b0; ticks(30);
    rst_n = 1'b0; tick();
    chk_reset_outs("midreset_outputs");
    rst_n = 1'b1;
    ticks(32);
    clear_stats();
    periods(1, 63, 62);
    chk("midreset_rise", n_rise, 1);
    chk("midreset_no_vld", n_vld, 0);
    chk("midreset_unlocked", locked, 0);
    periods(4, 63, 62);
    chk("midreset_relock_at_vld_n", lock_vld_n, 4);

    // Bad duty cycle: 40 high of 125
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    clear_stats();
    periods(6, 40, 85);
    chk("duty_vlds", n_vld, 5);
    chk("duty_period", min_per, 125);
`ifdef SLOWCLK_DUTY_CHECK_EN
    chk("duty_high_time", high_time, 40);
    chk("duty_err_count", n_derr, 5);
    chk("duty_no_lock", n_lockup, 0);
    chk("duty_locked", locked, 0);
`else
    chk("duty_high_time", high_time, 0);
    chk("duty_err_count", n_derr, 0);
    chk("duty_locked", locked, 1);
    chk("duty_lock_at_vld_n", lock_vld_n, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
